spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter HALF_PERIOD, default 4: SCLK half-period in clk cycles; legal range >=2.
REQ-002 Parameter WIDTH, default 8: data byte width; the address field is WIDTH-1 bits plus one R/W bit.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a transaction; sampled only in IDLE.
REQ-006 rw  input  1  1 = read, 0 = write; latched on accept.
REQ-007 addr  input  WIDTH-1  target address; latched on accept.
REQ-008 wdata  input  WIDTH  write data; latched on accept.
REQ-009 rdata  output  WIDTH  data captured by the last completed read.
REQ-010 busy  output  1  high from the accept cycle until the return to IDLE.
REQ-011 done  output  1  one-cycle pulse at transaction end.
REQ-012 sclk  output  1  SPI clock, mode 0 (idle low).
REQ-013 cs_n  output  1  chip select, active low.
REQ-014 mosi  output  1  serial data to the slave, MSB first.
REQ-015 miso  input  1  serial data from the slave, MSB first.

Function
REQ-016 The FSM SHALL use states IDLE, SETUP, ADDR, DATA, HOLD, RECOVER.
REQ-017 IDLE with start=1 at a clk edge SHALL accept the request: latch rw, addr, wdata; busy=1 from the next cycle; move to SETUP.
REQ-018 start asserted while busy=1 SHALL be ignored; it is neither queued nor latched.
REQ-019 SETUP SHALL drive cs_n=0 and mosi=addr[WIDTH-2], hold sclk=0 for HALF_PERIOD cycles, then enter ADDR.
REQ-020 Each bit SHALL be one SCLK period: sclk high for HALF_PERIOD cycles, then low for HALF_PERIOD cycles.
REQ-021 mosi SHALL change only on sclk falling edges, or in SETUP for the first bit.
REQ-022 miso SHALL be sampled on clk cycles where sclk rises.
REQ-023 ADDR SHALL shift out WIDTH bits: addr MSB first, then rw as the last bit.
REQ-024 DATA SHALL shift WIDTH bits, MSB first. On write, mosi carries wdata. On read, mosi=0 and the WIDTH miso samples are assembled MSB first.
REQ-025 After the final falling edge, HOLD SHALL keep cs_n=0 and sclk=0 for HALF_PERIOD cycles.
REQ-026 At the end of HOLD: cs_n=1, done=1 for exactly one cycle; on a read, rdata updates in the same cycle.
REQ-027 On a write, rdata SHALL retain its previous value.
REQ-028 RECOVER SHALL hold cs_n=1 and busy=1 for HALF_PERIOD cycles, then enter IDLE with busy=0.
REQ-029 start=1 on the first IDLE cycle after RECOVER SHALL be accepted; back-to-back transactions are allowed.
REQ-030 cs_n SHALL be low for exactly (2+4*WIDTH)*HALF_PERIOD cycles per transaction: 136 at the defaults.
REQ-031 Bit and half-period counters SHALL wrap cleanly and SHALL NOT produce extra or truncated sclk pulses at the ADDR-to-DATA boundary.
REQ-032 sclk SHALL be low whenever cs_n transitions.

Reset
REQ-033 reset_n=0 SHALL immediately force IDLE, sclk=0, cs_n=1, mosi=0, busy=0, done=0, rdata=0, and clear all counters.
REQ-034 Reset mid-transaction SHALL abort with no done pulse and no rdata update; after release the block idles until a new start.
REQ-035 Reset release SHALL not by itself start a transaction.

Structure
REQ-036 A shared package spi_pkg SHALL hold the state enum, the WIDTH default, and the mode-0 polarity constants.
REQ-037 A sub-module spi_sclk_gen SHALL provide the half-period counter, rise/fall strobes, and the sclk register, enabled by the FSM.
REQ-038 A single WIDTH-bit shift register SHALL serve both TX and RX, with parallel load at accept and at the ADDR-to-DATA boundary.

Verification
REQ-039 Write: addr=7'h15, rw=0, wdata=8'hA5 -> mosi bits 0010101_0 then 10100101; done once; cs_n low for 136 cycles.
REQ-040 Read: addr=7'h3F, rw=1, slave model returns 8'h5C on miso -> rdata=8'h5C when done=1; mosi=0 during DATA.
REQ-041 start held high through the whole transaction -> exactly one accepted per pass through IDLE; the second begins on the first IDLE cycle.
REQ-042 reset_n pulsed low at bit 5 of DATA -> cs_n=1 and sclk=0 at once; no done pulse; rdata unchanged at 0.
REQ-043 HALF_PERIOD=2 -> sclk period of 4 clk cycles; miso sampled only on rising edges; 16 rising edges counted per transaction.
REQ-044 Write after a read with rdata=8'h5C -> rdata stays 8'h5C.

Source files
------------

// File: rtl/spi_pkg.sv
// SPI master shared definitions: state codes,
// default data width and mode-0 polarity levels.
package spi_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic SCLK_IDLE = 1'b0;
  localparam logic CS_IDLE   = 1'b1;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_SETUP   = 3'd1;
  localparam state_t S_ADDR    = 3'd2;
  localparam state_t S_DATA    = 3'd3;
  localparam state_t S_HOLD    = 3'd4;
  localparam state_t S_RECOVER = 3'd5;

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period timer and SCLK register with rise/fall
// strobes; counts only while the FSM enables it.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic tog_en,
  output logic tick,
  output logic rise,
  output logic fall,
  output logic sclk
);

  localparam int CW = $clog2(HALF_PERIOD);
  localparam logic [CW-1:0] CMAX = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;

  assign tick = en && (cnt_q == CMAX);
  assign rise = tick && tog_en && (sclk_q == SCLK_IDLE);
  assign fall = tick && tog_en && (sclk_q != SCLK_IDLE);
  assign sclk = sclk_q;

  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    sclk_d = sclk_q;
    if (!en) begin
      cnt_d  = '0;
      sclk_d = SCLK_IDLE;
    end else if (tick) begin
      cnt_d = '0;
      if (tog_en) sclk_d = !sclk_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      sclk_q <= SCLK_IDLE;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: address+R/W byte followed by
// one data byte, through a shared TX/RX shift register.
module spi_master
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int WIDTH       = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             rw,
  input  logic [WIDTH-2:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             cs_n,
  output logic             mosi,
  input  logic             miso
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] BLAST = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BEND  = BW'(WIDTH);

  state_t           state_q, state_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rw_q, rw_d;
  logic             miso_q, miso_d;
  logic             done_q, done_d;
  logic             tick, rise, fall;
  logic             gen_en, tog_en;
  logic             active, tx_en;

  assign gen_en = (state_q != S_IDLE);
  // After the last data fall, SCLK stays low into HOLD.
  assign tog_en = (state_q == S_SETUP) || (state_q == S_ADDR) ||
                  ((state_q == S_DATA) && (bit_q != BEND));

  spi_sclk_gen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_sclk (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (gen_en),
    .tog_en (tog_en),
    .tick   (tick),
    .rise   (rise),
    .fall   (fall),
    .sclk   (sclk)
  );

  assign active = (state_q == S_SETUP) || (state_q == S_ADDR) ||
                  (state_q == S_DATA)  || (state_q == S_HOLD);
  assign tx_en  = (state_q == S_SETUP) || (state_q == S_ADDR) ||
                  ((state_q == S_DATA) && !rw_q && (bit_q != BEND));

  assign cs_n  = active ? !CS_IDLE : CS_IDLE;
  assign mosi  = tx_en & sreg_q[WIDTH-1];
  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;
  assign rdata = rdata_q;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sreg_d  = sreg_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rw_d    = rw_q;
    miso_d  = miso_q;
    done_d  = 1'b0;
    if (rise) miso_d = miso;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETUP;
          rw_d    = rw;
          wdata_d = wdata;
          sreg_d  = {addr, rw};
          bit_d   = '0;
        end
      end
      S_SETUP: begin
        if (tick) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (fall) begin
          if (bit_q == BLAST) begin
            state_d = S_DATA;
            bit_d   = '0;
            sreg_d  = rw_q ? '0 : wdata_q;
          end else begin
            bit_d  = bit_q + BW'(1);
            sreg_d = {sreg_q[WIDTH-2:0], miso_q};
          end
        end
      end
      S_DATA: begin
        if (fall) begin
          bit_d  = bit_q + BW'(1);
          sreg_d = {sreg_q[WIDTH-2:0], miso_q};
        end
        if (tick && (bit_q == BEND)) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (tick) begin
          state_d = S_RECOVER;
          done_d  = 1'b1;
          if (rw_q) rdata_d = sreg_q;
        end
      end
      S_RECOVER: begin
        if (tick) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      sreg_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rw_q    <= 1'b0;
      miso_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rw_q    <= rw_d;
      miso_q  <= miso_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master at HALF_PERIOD 4 and 2 with a
// bus monitor and mode-0 slave model.
`timescale 1ns/1ps
module tb_spi_master;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         rw = 1'b0;
  logic [W-2:0] addr = '0;
  logic [W-1:0] wdata = '0;
  logic         start [2] = '{1'b0, 1'b0};
  logic         miso [2] = '{1'b0, 1'b0};
  logic [W-1:0] sdata [2] = '{8'h00, 8'h00};
  logic [W-1:0] rdata [2];
  logic         busy [2];
  logic         done [2];
  logic         sclk [2];
  logic         cs_n [2];
  logic         mosi [2];

  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_rd [2] = '{8'h00, 8'h00};

  int n_rise [2] = '{0, 0};
  int cs_low [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int mosi_viol [2] = '{0, 0};
  int sclk_viol [2] = '{0, 0};
  logic [2*W-1:0] mosi_log [2] = '{16'h0, 16'h0};
  logic sc_p [2] = '{1'b0, 1'b0};
  logic cs_p [2] = '{1'b1, 1'b1};
  logic mo_p [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    spi_master #(
      .HALF_PERIOD(g == 0 ? 4 : 2),
      .WIDTH      (W)
    ) u_dut (
      .clk    (clk),
      .reset_n(reset_n),
      .start  (start[g]),
      .rw     (rw),
      .addr   (addr),
      .wdata  (wdata),
      .rdata  (rdata[g]),
      .busy   (busy[g]),
      .done   (done[g]),
      .sclk   (sclk[g]),
      .cs_n   (cs_n[g]),
      .mosi   (mosi[g]),
      .miso   (miso[g])
    );
  end

  // Bus monitor and slave: miso is junk while sclk is high.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (cs_n[g] != cs_p[g] && sclk[g])
        sclk_viol[g] <= sclk_viol[g] + 1;
      if (done[g]) done_cnt[g] <= done_cnt[g] + 1;
      if (!cs_n[g] && cs_p[g]) begin
        n_rise[g]    <= 0;
        cs_low[g]    <= 1;
        done_cnt[g]  <= 0;
        mosi_viol[g] <= 0;
        mosi_log[g]  <= '0;
      end else begin
        if (!cs_n[g]) cs_low[g] <= cs_low[g] + 1;
        if (!cs_n[g] && mosi[g] != mo_p[g] && !(sc_p[g] && !sclk[g]))
          mosi_viol[g] <= mosi_viol[g] + 1;
        if (sclk[g] && !sc_p[g]) begin
          mosi_log[g] <= {mosi_log[g][2*W-2:0], mosi[g]};
          n_rise[g]   <= n_rise[g] + 1;
          miso[g]     <= 1'($urandom);
        end else if (!sclk[g] && sc_p[g]) begin
          if (n_rise[g] >= W && n_rise[g] < 2*W)
            miso[g] <= sdata[g][2*W-1-n_rise[g]];
          else
            miso[g] <= 1'($urandom);
        end
      end
      sc_p[g] <= sclk[g];
      cs_p[g] <= cs_n[g];
      mo_p[g] <= mosi[g];
    end
  end

  function automatic int hp(input int g);
    return (g == 0) ? 4 : 2;
  endfunction

  function automatic logic [2*W-1:0] exp_bits(
    input logic r, input logic [W-2:0] a, input logic [W-1:0] w);
    return {a, r, (r ? 8'h00 : w)};
  endfunction

  task automatic run_txn(
    input  int           g,
    input  logic         r,
    input  logic [W-2:0] a,
    input  logic [W-1:0] w,
    input  logic [W-1:0] s,
    output logic         bsy,
    output logic [W-1:0] rd_at_done,
    output int           tmo
  );
    int n;
    sdata[g] = s;
    rw = r;
    addr = a;
    wdata = w;
    start[g] = 1'b1;
    @(posedge clk); #1;
    start[g] = 1'b0;
    bsy = busy[g];
    tmo = 0;
    n = 0;
    while (!done[g] && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 1000) tmo = 1;
    rd_at_done = rdata[g];
    n = 0;
    while (busy[g] && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) tmo = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({sclk[0], cs_n[0], mosi[0], busy[0], done[0]} !== 5'b01000) begin
      bad++;
      $display("FAIL reset_outs: got %b want 01000",
               {sclk[0], cs_n[0], mosi[0], busy[0], done[0]});
    end
    total++;
    if (rdata[0] !== 8'h00 || rdata[1] !== 8'h00) begin
      bad++;
      $display("FAIL reset_rdata: got %h/%h want 00/00", rdata[0], rdata[1]);
    end
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    total++;
    if (busy[0] !== 1'b0 || cs_n[0] !== 1'b1 || busy[1] !== 1'b0) begin
      bad++;
      $display("FAIL release_idle: got busy=%b cs_n=%b want 0 1", busy[0], cs_n[0]);
    end
  endtask

  task automatic test_write();
    logic bsy;
    logic [W-1:0] rd;
    int tmo;
    run_txn(0, 1'b0, 7'h15, 8'hA5, 8'($urandom), bsy, rd, tmo);
    total++;
    if (tmo !== 0 || bsy !== 1'b1) begin
      bad++;
      $display("FAIL write_handshake: got tmo=%0d busy=%b want 0 1", tmo, bsy);
    end
    total++;
    if (mosi_log[0] !== 16'b0010101_0_10100101) begin
      bad++;
      $display("FAIL write_mosi: got %b want 0010101010100101", mosi_log[0]);
    end
    total++;
    if (cs_low[0] !== 136) begin
      bad++;
      $display("FAIL write_cs_low: got %0d want 136", cs_low[0]);
    end
    total++;
    if (done_cnt[0] !== 1 || n_rise[0] !== 16 || mosi_viol[0] !== 0) begin
      bad++;
      $display("FAIL write_pulses: got done=%0d rises=%0d mviol=%0d want 1 16 0",
               done_cnt[0], n_rise[0], mosi_viol[0]);
    end
    total++;
    if (rdata[0] !== exp_rd[0]) begin
      bad++;
      $display("FAIL write_rdata: got %h want %h", rdata[0], exp_rd[0]);
    end
  endtask

  task automatic test_read();
    logic bsy;
    logic [W-1:0] rd;
    int tmo;
    run_txn(0, 1'b1, 7'h3F, 8'($urandom), 8'h5C, bsy, rd, tmo);
    exp_rd[0] = 8'h5C;
    total++;
    if (tmo !== 0 || rd !== 8'h5C) begin
      bad++;
      $display("FAIL read_rdata_at_done: got %h tmo=%0d want 5c", rd, tmo);
    end
    total++;
    if (mosi_log[0] !== exp_bits(1'b1, 7'h3F, 8'h00) || mosi_viol[0] !== 0) begin
      bad++;
      $display("FAIL read_mosi: got %b want %b", mosi_log[0],
               exp_bits(1'b1, 7'h3F, 8'h00));
    end
    total++;
    if (done_cnt[0] !== 1 || cs_low[0] !== 136) begin
      bad++;
      $display("FAIL read_frame: got done=%0d cs_low=%0d want 1 136",
               done_cnt[0], cs_low[0]);
    end
  endtask

  task automatic test_write_after_read();
    logic bsy;
    logic [W-1:0] rd;
    int tmo;
    logic [W-2:0] a;
    logic [W-1:0] w;
    a = 7'($urandom);
    w = 8'($urandom);
    run_txn(0, 1'b0, a, w, 8'($urandom), bsy, rd, tmo);
    total++;
    if (tmo !== 0 || rdata[0] !== 8'h5C) begin
      bad++;
      $display("FAIL war_rdata: got %h want 5c", rdata[0]);
    end
    total++;
    if (mosi_log[0] !== exp_bits(1'b0, a, w)) begin
      bad++;
      $display("FAIL war_mosi: got %h want %h", mosi_log[0], exp_bits(1'b0, a, w));
    end
  endtask

  task automatic test_fast();
    logic bsy;
    logic [W-1:0] rd;
    logic [W-1:0] s;
    int tmo;
    s = 8'($urandom);
    run_txn(1, 1'b1, 7'($urandom), 8'($urandom), s, bsy, rd, tmo);
    exp_rd[1] = s;
    total++;
    if (tmo !== 0 || rd !== s) begin
      bad++;
      $display("FAIL fast_rdata: got %h want %h", rd, s);
    end
    total++;
    if (cs_low[1] !== 68 || n_rise[1] !== 16) begin
      bad++;
      $display("FAIL fast_frame: got cs_low=%0d rises=%0d want 68 16",
               cs_low[1], n_rise[1]);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int gap;
    int ndone;
    logic [W-2:0] a;
    logic [W-1:0] w;
    a = 7'($urandom);
    w = 8'($urandom);
    rw = 1'b0;
    addr = a;
    wdata = w;
    start[0] = 1'b1;
    n = 0;
    ndone = 0;
    while (!done[0] && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    if (done[0]) ndone++;
    while (busy[0] && n < 1100) begin
      @(posedge clk); #1; n++;
    end
    gap = 0;
    while (!busy[0] && n < 1200) begin
      gap++;
      @(posedge clk); #1; n++;
    end
    start[0] = 1'b0;
    total++;
    if (gap !== 1 || n >= 1000) begin
      bad++;
      $display("FAIL b2b_gap: got %0d idle cycles want 1", gap);
    end
    n = 0;
    while (!done[0] && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    if (done[0]) ndone++;
    repeat (40) @(posedge clk);
    #1;
    total++;
    if (ndone !== 2 || busy[0] !== 1'b0 || done_cnt[0] !== 1) begin
      bad++;
      $display("FAIL b2b_count: got dones=%0d busy=%b want 2 0", ndone, busy[0]);
    end
    total++;
    if (mosi_log[0] !== exp_bits(1'b0, a, w) || cs_low[0] !== 136) begin
      bad++;
      $display("FAIL b2b_second: got %h cs_low=%0d want %h 136",
               mosi_log[0], cs_low[0], exp_bits(1'b0, a, w));
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int saw_done;
    rw = 1'b1;
    addr = 7'($urandom);
    sdata[0] = 8'($urandom);
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    n = 0;
    saw_done = 0;
    while (n_rise[0] < W + 6 && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (cs_n[0] !== 1'b1 || sclk[0] !== 1'b0 || busy[0] !== 1'b0 || n >= 1000) begin
      bad++;
      $display("FAIL midreset_abort: got cs_n=%b sclk=%b busy=%b want 1 0 0",
               cs_n[0], sclk[0], busy[0]);
    end
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (80) begin
      @(posedge clk); #1;
      if (done[0]) saw_done++;
    end
    total++;
    if (saw_done !== 0 || rdata[0] !== 8'h00 || busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL midreset_after: got done=%0d rdata=%h busy=%b want 0 00 0",
               saw_done, rdata[0], busy[0]);
    end
  endtask

  task automatic test_random();
    logic bsy;
    logic [W-1:0] rd;
    int tmo;
    int g;
    logic r;
    logic [W-2:0] a;
    logic [W-1:0] w;
    logic [W-1:0] s;
    for (int i = 0; i < 8; i++) begin
      g = int'($urandom_range(0, 1));
      r = 1'($urandom);
      a = 7'($urandom);
      w = 8'($urandom);
      s = 8'($urandom);
      run_txn(g, r, a, w, s, bsy, rd, tmo);
      if (r) exp_rd[g] = s;
      total++;
      if (tmo !== 0 || rdata[g] !== exp_rd[g]) begin
        bad++;
        $display("FAIL rand%0d_rdata: got %h want %h", i, rdata[g], exp_rd[g]);
      end
      total++;
      if (mosi_log[g] !== exp_bits(r, a, w) || mosi_viol[g] !== 0) begin
        bad++;
        $display("FAIL rand%0d_mosi: got %h want %h", i, mosi_log[g],
                 exp_bits(r, a, w));
      end
      total++;
      if (cs_low[g] !== (2 + 4 * W) * hp(g) || done_cnt[g] !== 1) begin
        bad++;
        $display("FAIL rand%0d_frame: got cs_low=%0d done=%0d want %0d 1",
                 i, cs_low[g], done_cnt[g], (2 + 4 * W) * hp(g));
      end
    end
  endtask

  task automatic test_protocol();
    total++;
    if (sclk_viol[0] !== 0 || sclk_viol[1] !== 0) begin
      bad++;
      $display("FAIL sclk_at_cs_edge: got %0d/%0d want 0/0",
               sclk_viol[0], sclk_viol[1]);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_write_after_read();
    test_fast();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
